led_button_array: RTL and testbench
===================================

Name: led_button_array

Overview:
- Parametrised multi-channel successor to the single-button LED toggle FSM.
- Each channel synchronises and debounces a raw push-button input, then toggles its LED when a press is released.
- Each channel also emits a one-cycle toggle pulse for downstream logic.
- Sits directly between the board push-buttons and the LED drivers or user-logic event inputs.

Parameters:
- CHANNELS, 4, number of independent button/LED channels (>=1).
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from the debounced value before the debounced value changes (>=1).
- LONG_CYCLES, 16, cycles a debounced press must be held to count as a long press (>=2). Used only with LONG_PRESS_EN.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- p  in  CHANNELS  raw, asynchronous button levels, 1 = pressed.
- led  out  CHANNELS  LED drive per channel, 1 = on.
- toggle_pulse  out  CHANNELS  one-cycle strobe when that channel's LED toggles.
- long_press  out  CHANNELS  one-cycle strobe on long-press detection (tied 0 without LONG_PRESS_EN).

Behaviour:
- Reset values (while rst=1 at a clk edge):
  - all synchroniser flops, debounced values and counters = 0
  - every channel state = IDLE_OFF
  - led = 0, toggle_pulse = 0, long_press = 0
- Channels are fully independent. Simultaneous activity on several channels is processed in parallel with no arbitration.
- Synchroniser: two-flop chain per channel, giving p_sync.
- Debouncer:
  - Per-channel counter, width clog2(DEBOUNCE_CYCLES)+1.
  - If p_sync == db, the counter clears.
  - If p_sync != db, the counter increments. When the counter == DEBOUNCE_CYCLES-1 and the mismatch persists, db <= p_sync and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES sampled cycles leaves db unchanged.
- FSM per channel:
  - States: IDLE_OFF, PRESSED_OFF, IDLE_ON, PRESSED_ON (plus LONG_HELD under LONG_PRESS_EN).
  - IDLE_OFF -> PRESSED_OFF on db=1.
  - PRESSED_OFF -> IDLE_ON on db=0.
  - IDLE_ON -> PRESSED_ON on db=1.
  - PRESSED_ON -> IDLE_OFF on db=0.
  - Otherwise the state holds.
  - The LED changes on release, not on press.
- led decoding: combinational from the registered state; 1 in IDLE_ON and PRESSED_ON, else 0.
- toggle_pulse: registered. High exactly the cycle after a PRESSED_* -> IDLE_* transition, i.e. coincident with the new led value.
- Latency: define edge 0 as the first clk edge that samples a new stable p level.
  - p_sync changes after edge 1.
  - db changes at edge 1+DEBOUNCE_CYCLES.
  - State/led change at edge 2+DEBOUNCE_CYCLES.
  - toggle_pulse is high in the cycle following that edge.
  - With defaults, led toggles 6 edges after the release is first sampled.
- Reset mid-operation: the channel returns to IDLE_OFF with led off. A button still held after reset is seen as a fresh press (db restarts at 0), and its release turns the LED on.
- DEBOUNCE_CYCLES=1: db follows p_sync with one cycle of delay.

Optional Feature:
- Macro: LONG_PRESS_EN.
- Defined:
  - A per-channel hold counter runs while in PRESSED_OFF or PRESSED_ON and clears in any other state.
  - When the hold counter reaches LONG_CYCLES-1 with db still 1, the state goes to LONG_HELD: led=0, long_press pulses for one cycle.
  - LONG_HELD -> IDLE_OFF on db=0, with no toggle_pulse.
  - A release before LONG_CYCLES behaves as a normal toggle.
- Undefined: no hold counter and no LONG_HELD state; long_press is driven constant 0.

Decomposition:
- Package led_button_pkg:
  - state typedef, 3-bit encoded so LONG_HELD fits
  - state encodings
  - helper localparam/function for counter widths
- Sub-module led_button_chan: one channel containing synchroniser, debouncer, FSM and optional long-press logic.
- led_button_array is a generate loop of CHANNELS instances.

Test Plan:
- Reset, then p=0 for 20 cycles -> led=0000, no pulses.
- Channel 0 pressed 10 cycles, then released (defaults) -> led[0]=0 throughout the press; led[0]=1 at edge 6 after release sampling; toggle_pulse[0] high exactly 1 cycle; second press/release returns led[0]=0.
- Channel 1 glitches: 3-cycle pulses separated by 3 low cycles, repeated 5 times -> led[1], db and toggle_pulse unchanged.
- Channels 0 and 3 pressed and released on identical cycles -> both LEDs toggle on the same edge, with both pulses high in the same cycle.
- rst asserted mid-press with led[2]=1, p[2] kept high -> after reset led[2]=0; release -> led[2]=1 with toggle_pulse.
- LONG_PRESS_EN defined, channel 0 on, p[0] held 30 cycles -> long_press[0] pulses once and led[0]=0 while held; release -> led[0]=0, no toggle_pulse.

Source files
------------

// File: rtl/led_button_pkg.sv
// ---------------------------------------------------------------------------
// led_button_pkg
// Shared definitions for the push-button / LED channel array.
//   chan_state_t : per-channel FSM state, 3 bits wide so the long-press
//                  hold state has an encoding even in builds without it.
//   cnt_width()  : width of a counter that must hold values 0..max_count.
// ---------------------------------------------------------------------------
package led_button_pkg;

   typedef enum logic [2:0] {
      IDLE_OFF    = 3'd0,
      PRESSED_OFF = 3'd1,
      IDLE_ON     = 3'd2,
      PRESSED_ON  = 3'd3,
      LONG_HELD   = 3'd4
   } chan_state_t;

   // One extra bit beyond clog2 so the counter never wraps before its
   // terminal compare, even when max_count is a power of two.
   function automatic int cnt_width(input int max_count);
      return $clog2(max_count) + 1;
   endfunction

endpackage

// File: rtl/led_button_chan.sv
// ---------------------------------------------------------------------------
// led_button_chan
// One button/LED channel: two-flop synchroniser, counter debouncer and a
// toggle FSM that flips the LED when a debounced press is released.
//
// Optional feature macro: LONG_PRESS_EN
//   When defined, a hold counter runs while the button is pressed; holding
//   for LONG_CYCLES cycles parks the channel in LONG_HELD (LED off) and
//   strobes long_press. Releasing from LONG_HELD returns to IDLE_OFF with
//   no toggle strobe. When undefined, long_press is tied to 0.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   p            in   raw asynchronous button level, 1 = pressed
//   led          out  LED drive, 1 = on (decoded from the state register)
//   toggle_pulse out  one-cycle strobe coincident with a new LED value
//   long_press   out  one-cycle strobe on long-press detection
// ---------------------------------------------------------------------------
module led_button_chan
   import led_button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LONG_CYCLES     = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic p,
   output logic led,
   output logic toggle_pulse,
   output logic long_press
);

   localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);

   // Reject nonsensical parameterisations at elaboration time.
   if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 2) begin : g_param_check
      $error("led_button_chan: DEBOUNCE_CYCLES must be >= 1 and LONG_CYCLES >= 2");
   end

   logic            p_meta;
   logic            p_sync;
   logic            db;
   logic [DB_W-1:0] db_cnt;
   chan_state_t     state;
   chan_state_t     state_next;
   logic            toggle_next;

   // Two-flop synchroniser bringing the asynchronous button into clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_meta <= 1'b0;
         p_sync <= 1'b0;
      end else begin
         p_meta <= p;
         p_sync <= p_meta;
      end
   end

   // Debouncer: db only follows p_sync after DEBOUNCE_CYCLES consecutive
   // mismatching samples; any agreement in between restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         db     <= 1'b0;
         db_cnt <= '0;
      end else if (p_sync == db) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
         db     <= p_sync;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + DB_W'(1);
      end
   end

`ifdef LONG_PRESS_EN
   localparam int HOLD_W = cnt_width(LONG_CYCLES);

   logic [HOLD_W-1:0] hold_cnt;
   logic              hold_done;
   logic              long_next;

   assign hold_done = (hold_cnt == HOLD_W'(LONG_CYCLES - 1));

   // Hold counter measures how long the current press has lasted; it is
   // cleared in every non-pressed state so each press starts from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt   <= '0;
         long_press <= 1'b0;
      end else begin
         long_press <= long_next;
         if (state == PRESSED_OFF || state == PRESSED_ON) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end else begin
            hold_cnt <= '0;
         end
      end
   end
`else
   assign long_press = 1'b0;
`endif

   // State register plus the registered toggle strobe, which lands in the
   // same cycle as the LED value it announces.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE_OFF;
         toggle_pulse <= 1'b0;
      end else begin
         state        <= state_next;
         toggle_pulse <= toggle_next;
      end
   end

   // Next-state logic: the LED flips on release, not on press. A release
   // takes priority over long-press detection when both occur together.
   always_comb begin
      state_next  = state;
      toggle_next = 1'b0;
`ifdef LONG_PRESS_EN
      long_next   = 1'b0;
`endif
      case (state)
         IDLE_OFF: begin
            if (db) state_next = PRESSED_OFF;
         end
         PRESSED_OFF: begin
            if (!db) begin
               state_next  = IDLE_ON;
               toggle_next = 1'b1;
            end
`ifdef LONG_PRESS_EN
            else if (hold_done) begin
               state_next = LONG_HELD;
               long_next  = 1'b1;
            end
`endif
         end
         IDLE_ON: begin
            if (db) state_next = PRESSED_ON;
         end
         PRESSED_ON: begin
            if (!db) begin
               state_next  = IDLE_OFF;
               toggle_next = 1'b1;
            end
`ifdef LONG_PRESS_EN
            else if (hold_done) begin
               state_next = LONG_HELD;
               long_next  = 1'b1;
            end
`endif
         end
`ifdef LONG_PRESS_EN
         LONG_HELD: begin
            if (!db) state_next = IDLE_OFF;
         end
`endif
         default: begin
            state_next = IDLE_OFF;
         end
      endcase
   end

   assign led = (state == IDLE_ON) || (state == PRESSED_ON);

endmodule

// File: rtl/led_button_array.sv
// ---------------------------------------------------------------------------
// led_button_array
// CHANNELS independent button/LED toggle channels, processed in parallel.
// Optional feature macro: LONG_PRESS_EN (see led_button_chan).
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   p            in   [CHANNELS] raw button levels, 1 = pressed
//   led          out  [CHANNELS] LED drive, 1 = on
//   toggle_pulse out  [CHANNELS] one-cycle strobe when an LED toggles
//   long_press   out  [CHANNELS] one-cycle long-press strobe (0 if disabled)
// ---------------------------------------------------------------------------
module led_button_array
   import led_button_pkg::*;
#(
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LONG_CYCLES     = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] p,
   output logic [CHANNELS-1:0] led,
   output logic [CHANNELS-1:0] toggle_pulse,
   output logic [CHANNELS-1:0] long_press
);

   // One self-contained channel per button; no shared state between them.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      led_button_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_chan (
         .clk          (clk),
         .rst          (rst),
         .p            (p[i]),
         .led          (led[i]),
         .toggle_pulse (toggle_pulse[i]),
         .long_press   (long_press[i])
      );
   end

endmodule

// File: tb/tb_led_button_array.sv
// ---------------------------------------------------------------------------
// tb_led_button_array
// Directed, table-driven bench for led_button_array with default parameters.
// Each row drives rst/p at a falling edge and then, for n cycles, compares
// led, toggle_pulse and long_press at every following falling edge.
// ---------------------------------------------------------------------------
module tb_led_button_array;

   logic       clk;
   logic       rst;
   logic [3:0] p;
   logic [3:0] led;
   logic [3:0] toggle_pulse;
   logic [3:0] long_press;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst;
      logic [3:0] p;
      int         n;
      logic [3:0] led;
      logic [3:0] tp;
      logic [3:0] lp;
   } vec_t;

   vec_t vecs[$];

   led_button_array #(
      .CHANNELS        (4),
      .DEBOUNCE_CYCLES (4),
      .LONG_CYCLES     (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .p            (p),
      .led          (led),
      .toggle_pulse (toggle_pulse),
      .long_press   (long_press)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void add_vec(input logic r, input logic [3:0] pv, input int n,
                                   input logic [3:0] l, input logic [3:0] t,
                                   input logic [3:0] lp);
      vec_t v;
      v.rst = r;
      v.p   = pv;
      v.n   = n;
      v.led = l;
      v.tp  = t;
      v.lp  = lp;
      vecs.push_back(v);
   endfunction

   task automatic apply_stimulus(input logic r, input logic [3:0] pv);
      rst = r;
      p   = pv;
   endtask

   task automatic check_output(input string name, input logic [3:0] actual,
                               input logic [3:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
      end
   endtask

   // Drive one row, then compare all outputs after each of its n cycles.
   task automatic run_row(input vec_t v, input string tag);
      apply_stimulus(v.rst, v.p);
      for (int c = 0; c < v.n; c++) begin
         @(negedge clk);
         check_output($sformatf("%s.c%0d.led", tag, c), led, v.led);
         check_output($sformatf("%s.c%0d.toggle_pulse", tag, c), toggle_pulse, v.tp);
         check_output($sformatf("%s.c%0d.long_press", tag, c), long_press, v.lp);
      end
   endtask

   initial begin
      apply_stimulus(1'b1, 4'b0000);

      // Reset and idle.
      add_vec(1, 4'b0000,  2, 4'b0000, 4'b0000, 4'b0000);
      add_vec(0, 4'b0000, 20, 4'b0000, 4'b0000, 4'b0000);
      // Channel 0: press 10 cycles, release; LED turns on at edge 6 of release.
      add_vec(0, 4'b0001, 10, 4'b0000, 4'b0000, 4'b0000);
      add_vec(0, 4'b0000,  6, 4'b0000, 4'b0000, 4'b0000);
      add_vec(0, 4'b0000,  1, 4'b0001, 4'b0001, 4'b0000);
      add_vec(0, 4'b0000,  8, 4'b0001, 4'b0000, 4'b0000);
      // Channel 0: second press/release turns it off again.
      add_vec(0, 4'b0001, 10, 4'b0001, 4'b0000, 4'b0000);
      add_vec(0, 4'b0000,  6, 4'b0001, 4'b0000, 4'b0000);
      add_vec(0, 4'b0000,  1, 4'b0000, 4'b0001, 4'b0000);
      add_vec(0, 4'b0000,  5, 4'b0000, 4'b0000, 4'b0000);
      // Channel 1: five 3-cycle glitches are filtered out.
      for (int g = 0; g < 5; g++) begin
         add_vec(0, 4'b0010, 3, 4'b0000, 4'b0000, 4'b0000);
         add_vec(0, 4'b0000, 3, 4'b0000, 4'b0000, 4'b0000);
      end
      add_vec(0, 4'b0000,  8, 4'b0000, 4'b0000, 4'b0000);
      // Channel 1: a pulse of exactly DEBOUNCE_CYCLES gets through and toggles.
      add_vec(0, 4'b0010,  4, 4'b0000, 4'b0000, 4'b0000);
      add_vec(0, 4'b0000,  6, 4'b0000, 4'b0000, 4'b0000);
      add_vec(0, 4'b0000,  1, 4'b0010, 4'b0010, 4'b0000);
      add_vec(0, 4'b0000,  4, 4'b0010, 4'b0000, 4'b0000);
      // Channels 0 and 3 together.
      add_vec(0, 4'b1001, 10, 4'b0010, 4'b0000, 4'b0000);
      add_vec(0, 4'b0000,  6, 4'b0010, 4'b0000, 4'b0000);
      add_vec(0, 4'b0000,  1, 4'b1011, 4'b1001, 4'b0000);
      add_vec(0, 4'b0000,  5, 4'b1011, 4'b0000, 4'b0000);
      // Channel 2 on, then pressed again and reset while held.
      add_vec(0, 4'b0100, 10, 4'b1011, 4'b0000, 4'b0000);
      add_vec(0, 4'b0000,  6, 4'b1011, 4'b0000, 4'b0000);
      add_vec(0, 4'b0000,  1, 4'b1111, 4'b0100, 4'b0000);
      add_vec(0, 4'b0000,  3, 4'b1111, 4'b0000, 4'b0000);
      add_vec(0, 4'b0100, 10, 4'b1111, 4'b0000, 4'b0000);
      add_vec(1, 4'b0100,  2, 4'b0000, 4'b0000, 4'b0000);
      // Still held after reset: a fresh press, release turns LED 2 on.
      add_vec(0, 4'b0100, 10, 4'b0000, 4'b0000, 4'b0000);
      add_vec(0, 4'b0000,  6, 4'b0000, 4'b0000, 4'b0000);
      add_vec(0, 4'b0000,  1, 4'b0100, 4'b0100, 4'b0000);
      add_vec(0, 4'b0000,  4, 4'b0100, 4'b0000, 4'b0000);

      foreach (vecs[i]) run_row(vecs[i], $sformatf("row%0d", i));

`ifdef LONG_PRESS_EN
      // Long press on channel 0 while its LED is on: turn it on first.
      run_row('{0, 4'b0001, 10, 4'b0100, 4'b0000, 4'b0000}, "lp_on_press");
      run_row('{0, 4'b0000,  6, 4'b0100, 4'b0000, 4'b0000}, "lp_on_rel");
      run_row('{0, 4'b0000,  1, 4'b0101, 4'b0001, 4'b0000}, "lp_on_tog");
      run_row('{0, 4'b0000,  3, 4'b0101, 4'b0000, 4'b0000}, "lp_on_idle");
      // Hold 30 cycles: PRESSED_ON from edge 6, LONG_HELD at edge 22.
      run_row('{0, 4'b0001, 22, 4'b0101, 4'b0000, 4'b0000}, "lp_hold");
      run_row('{0, 4'b0001,  1, 4'b0100, 4'b0000, 4'b0001}, "lp_detect");
      run_row('{0, 4'b0001,  7, 4'b0100, 4'b0000, 4'b0000}, "lp_held");
      // Release from LONG_HELD: LED stays off, no toggle strobe.
      run_row('{0, 4'b0000, 12, 4'b0100, 4'b0000, 4'b0000}, "lp_release");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
